tick_gen: RTL

- Parametrised successor of the single fixed-period tick/LED-toggle generator.
- NCH independent channels, each with a runtime-programmable period and pulse width, plus a per-channel toggle output for LED heartbeat.
- Channels run only while the PLL reports lock and the channel is enabled.
- Sits after the PLL in the board top and drives tick outputs, LEDs and timestamp strobes.

---
 rtl/tick_pkg.sv | 14 +
 rtl/tick_chan.sv | 146 ++++++++++++++
 rtl/tick_gen.sv | 71 +++++++
 3 files changed

// File: rtl/tick_pkg.sv
// Shared constants and types for the tick_gen multi-channel tick/heartbeat generator.
package tick_pkg;

  localparam int unsigned CNT_W_DEF  = 32;
  localparam int unsigned CH_W       = 3;
  localparam int unsigned MIN_PERIOD = 2;
  localparam int unsigned MIN_WIDTH  = 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/tick_chan.sv
// One tick channel: IDLE/RUN FSM, period counter, shadow/active period and width
// registers with clamping on load, and registered tick/tog/running outputs.
module tick_chan
  import tick_pkg::*;
#(
  parameter int unsigned CNT_W          = CNT_W_DEF,
  parameter int unsigned DEFAULT_PERIOD = 124500000,
  parameter int unsigned DEFAULT_WIDTH  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run_req,
  input  logic             sync,
  input  logic             cfg_we,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_width,
  output logic             tick,
  output logic             tog,
  output logic             running
);

  state_t           state;
  state_t           state_next;

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] shadow_period;
  logic [CNT_W-1:0] shadow_width;
  logic [CNT_W-1:0] act_period;
  logic [CNT_W-1:0] act_width;
  logic [CNT_W-1:0] clamp_period;
  logic [CNT_W-1:0] clamp_width;

  logic             wrap_c;
  logic [CNT_W-1:0] cnt_next;
  logic             tick_next;
  logic             tog_next;
  logic             running_next;

  // cnt never exceeds act_period-1, so the increment cannot overflow
  assign cnt_inc = cnt + CNT_W'(1);

  // Shadow values are sanitised on their way into the active set
  always_comb begin
    clamp_period = shadow_period;
    if (shadow_period < CNT_W'(MIN_PERIOD)) begin
      clamp_period = CNT_W'(MIN_PERIOD);
    end
    clamp_width = shadow_width;
    if (shadow_width < CNT_W'(MIN_WIDTH)) begin
      clamp_width = CNT_W'(MIN_WIDTH);
    end
    if (clamp_width > (clamp_period - CNT_W'(1))) begin
      clamp_width = clamp_period - CNT_W'(1);
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (run_req)  state_next = RUN;
      RUN:     if (!run_req) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    wrap_c       = 1'b0;
    cnt_next     = '0;
    tick_next    = 1'b0;
    tog_next     = tog;
    running_next = 1'b0;
    case (state)
      IDLE: begin
        if (run_req) wrap_c = 1'b1;
      end
      RUN: begin
        if (run_req) begin
          if (sync || (cnt == (act_period - CNT_W'(1)))) begin
            wrap_c = 1'b1;
          end else begin
            cnt_next     = cnt_inc;
            tick_next    = (cnt_inc < act_width);
            running_next = 1'b1;
          end
        end
      end
      default: ;
    endcase
    if (wrap_c) begin
      cnt_next     = '0;
      tick_next    = 1'b1;
      tog_next     = ~tog;
      running_next = 1'b1;
    end
  end

  // Counter and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      tick    <= 1'b0;
      tog     <= 1'b0;
      running <= 1'b0;
    end else begin
      cnt     <= cnt_next;
      tick    <= tick_next;
      tog     <= tog_next;
      running <= running_next;
    end
  end

  // Shadow registers take writes at any time
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_period <= CNT_W'(DEFAULT_PERIOD);
      shadow_width  <= CNT_W'(DEFAULT_WIDTH);
    end else if (cfg_we) begin
      shadow_period <= cfg_period;
      shadow_width  <= cfg_width;
    end
  end

  // Active registers change only on a wrap, so a period is never cut short
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_period <= CNT_W'(DEFAULT_PERIOD);
      act_width  <= CNT_W'(DEFAULT_WIDTH);
    end else if (wrap_c) begin
      act_period <= clamp_period;
      act_width  <= clamp_width;
    end
  end

endmodule

// File: rtl/tick_gen.sv
// Multi-channel tick/LED-toggle generator gated by PLL lock.
// Optional external phase alignment via sync_in when TICK_SYNC_EN is defined.
module tick_gen
  import tick_pkg::*;
#(
  parameter int unsigned NCH            = 2,
  parameter int unsigned CNT_W          = CNT_W_DEF,
  parameter int unsigned DEFAULT_PERIOD = 124500000,
  parameter int unsigned DEFAULT_WIDTH  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             locked,
  input  logic [NCH-1:0]   en,
  input  logic             cfg_we,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_width,
  input  logic             sync_in,
  output logic [NCH-1:0]   tick,
  output logic [NCH-1:0]   tog,
  output logic [NCH-1:0]   running
);

  logic sync_evt;

`ifdef TICK_SYNC_EN
  logic [2:0] sync_sr;

  // Two-flop synchroniser, then a registered rising-edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_sr  <= '0;
      sync_evt <= 1'b0;
    end else begin
      sync_sr  <= {sync_sr[1:0], sync_in};
      sync_evt <= sync_sr[1] & ~sync_sr[2];
    end
  end
`else
  logic unused_sync;

  assign unused_sync = sync_in;
  assign sync_evt    = 1'b0;
`endif

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    logic we;

    // Indices with no channel match nothing, so such writes drop out here
    assign we = cfg_we && (cfg_ch == CH_W'(i));

    tick_chan #(
      .CNT_W          (CNT_W),
      .DEFAULT_PERIOD (DEFAULT_PERIOD),
      .DEFAULT_WIDTH  (DEFAULT_WIDTH)
    ) u_chan (
      .clk        (clk),
      .rst_n      (rst_n),
      .run_req    (locked & en[i]),
      .sync       (sync_evt),
      .cfg_we     (we),
      .cfg_period (cfg_period),
      .cfg_width  (cfg_width),
      .tick       (tick[i]),
      .tog        (tog[i]),
      .running    (running[i])
    );
  end

endmodule
